// File: rtl/i2c_rtc_slave.sv
// I2C slave with a 16-byte register file; bytes 2..8 form the RTC image, which
// the host can also load in parallel through rtc_load/rtc_in.
module i2c_rtc_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        scl,
    inout  logic        sda,
    output logic [55:0] rtc,
    input  logic        rtc_load,
    input  logic [55:0] rtc_in,
    output logic        rtc_written
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
    } state_t;

    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_bitcnt, w_cnt_nxt;
    logic [3:0] r_ptr, w_ptr_nxt;
    logic       r_done, w_done_nxt;
    logic       r_mack, w_mack_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic       r_wr_any, w_wr_any_nxt;
    logic       r_written, w_written_nxt;
    logic       w_we;
    logic [7:0] r_regs [16];

    logic       w_start, w_stop, w_rise, w_fall;
    logic [7:0] w_byte;
    logic [3:0] w_ptr_inc;

    assign w_start   = r_scl_s2 & r_sda_h & ~r_sda_s2;
    assign w_stop    = r_scl_s2 & ~r_sda_h & r_sda_s2;
    assign w_rise    = r_scl_s2 & ~r_scl_h;
    assign w_fall    = ~r_scl_s2 & r_scl_h;
    assign w_byte    = {r_shift[6:0], r_sda_s2};
    assign w_ptr_inc = r_ptr + 4'd1;

    assign sda         = r_sda_low ? 1'b0 : 1'bz;
    assign rtc         = {r_regs[2], r_regs[3], r_regs[4], r_regs[5],
                          r_regs[6], r_regs[7], r_regs[8]};
    assign rtc_written = r_written;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_bitcnt;
        w_ptr_nxt     = r_ptr;
        w_done_nxt    = r_done;
        w_mack_nxt    = r_mack;
        w_sda_low_nxt = r_sda_low;
        w_wr_any_nxt  = r_wr_any;
        w_written_nxt = 1'b0;
        w_we          = 1'b0;
        if (w_start || w_stop) begin
            // Either condition ends any write transaction in progress.
            w_written_nxt = r_wr_any;
            w_wr_any_nxt  = 1'b0;
            w_sda_low_nxt = 1'b0;
            w_cnt_nxt     = 3'd0;
            w_done_nxt    = 1'b0;
            w_state_nxt   = w_start ? StAddr : StIdle;
        end else begin
            case (r_state)
                StAddr, StPtr, StWdata: begin
                    if (w_rise && !r_done) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_done_nxt = 1'b1;
                            if (r_state == StPtr) begin
                                w_ptr_nxt = w_byte[3:0];
                            end
                            if (r_state == StWdata) begin
                                w_we         = 1'b1;
                                w_ptr_nxt    = w_ptr_inc;
                                w_wr_any_nxt = 1'b1;
                            end
                        end
                    end else if (w_fall && r_done) begin
                        // Byte complete: ACK starts on the falling edge after bit 8.
                        w_done_nxt    = 1'b0;
                        w_sda_low_nxt = 1'b1;
                        if (r_state == StPtr) begin
                            w_state_nxt = StPtrAck;
                        end else if (r_state == StWdata) begin
                            w_state_nxt = StWdataAck;
                        end else if (r_shift[7:1] == SLAVE_ADDR) begin
                            w_state_nxt = StAddrAck;
                        end else begin
                            w_state_nxt   = StIdle;
                            w_sda_low_nxt = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (w_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_cnt_nxt     = 3'd0;
                        if (r_shift[0]) begin
                            w_state_nxt   = StRdata;
                            w_shift_nxt   = r_regs[r_ptr];
                            w_sda_low_nxt = ~r_regs[r_ptr][7];
                        end else begin
                            w_state_nxt = StPtr;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (w_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_cnt_nxt     = 3'd0;
                        w_state_nxt   = StWdata;
                    end
                end
                StRdata: begin
                    if (w_rise) begin
                        w_cnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_done_nxt = 1'b1;
                        end
                    end else if (w_fall) begin
                        if (r_done) begin
                            w_done_nxt    = 1'b0;
                            w_sda_low_nxt = 1'b0;
                            w_state_nxt   = StRdataAck;
                        end else begin
                            w_shift_nxt   = {r_shift[6:0], 1'b0};
                            w_sda_low_nxt = ~r_shift[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (w_rise) begin
                        w_mack_nxt = ~r_sda_s2;
                    end else if (w_fall) begin
                        if (r_mack) begin
                            w_ptr_nxt     = w_ptr_inc;
                            w_shift_nxt   = r_regs[w_ptr_inc];
                            w_sda_low_nxt = ~r_regs[w_ptr_inc][7];
                            w_cnt_nxt     = 3'd0;
                            w_state_nxt   = StRdata;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
            r_state   <= StIdle;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_ptr     <= 4'd0;
            r_done    <= 1'b0;
            r_mack    <= 1'b0;
            r_sda_low <= 1'b0;
            r_wr_any  <= 1'b0;
            r_written <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= {scl, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_h} <= {sda, r_sda_s1, r_sda_s2};
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_done    <= w_done_nxt;
            r_mack    <= w_mack_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_wr_any  <= w_wr_any_nxt;
            r_written <= w_written_nxt;
            if (w_we) begin
                r_regs[r_ptr] <= w_byte;
            end
            // Host load is applied last so it overrides a same-cycle bus write.
            if (rtc_load) begin
                for (int i = 0; i < 7; i++) begin
                    r_regs[i + 2] <= rtc_in[8 * (6 - i) +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_rtc_slave.sv
// Bit-banged I2C master exercising i2c_rtc_slave; a scoreboard compares bus and
// port observations with a byte-array model of the register file.
module tb_i2c_rtc_slave;

    logic        mclk = 1'b0;
    logic        reset;
    logic        scl_m;
    logic        m_low;
    wire         sda_bus;
    logic [55:0] rtc;
    logic        rtc_load;
    logic [55:0] rtc_in;
    logic        rtc_written;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_rtc_slave #(.SLAVE_ADDR(7'h51)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .scl        (scl_m),
        .sda        (sda_bus),
        .rtc        (rtc),
        .rtc_load   (rtc_load),
        .rtc_in     (rtc_in),
        .rtc_written(rtc_written)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        string       name;
        logic [63:0] val;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    end_req  = 1'b0;
    bit    end_done = 1'b0;

    // Reference model
    logic [7:0] mdl_regs [16];
    logic [3:0] mdl_ptr;
    int         mdl_pulses;
    logic [7:0] tx_buf[$];

    int   n_pulses = 0;
    int   n_wide   = 0;
    logic prev_wr  = 1'b0;

    function automatic void expect_item(input string n, input logic [63:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        exp_q.push_back(it);
    endfunction

    function automatic void observe(input string n, input logic [63:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        obs_q.push_back(it);
    endfunction

    function automatic logic [55:0] mdl_rtc();
        return {mdl_regs[2], mdl_regs[3], mdl_regs[4], mdl_regs[5],
                mdl_regs[6], mdl_regs[7], mdl_regs[8]};
    endfunction

    function automatic void mdl_load(input logic [55:0] v);
        for (int i = 0; i < 7; i++) mdl_regs[i + 2] = v[8 * (6 - i) +: 8];
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 4'd0;
    endfunction

    always @(negedge mclk) begin : scoreboard
        item_t o;
        item_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s: got %h, no expected value queued", o.name, o.val);
            end else begin
                e = exp_q.pop_front();
                if (e.name != o.name || e.val !== o.val) begin
                    n_errors++;
                    $display("FAIL %s: got %h required %h (expected item %s)",
                             o.name, o.val, e.val, e.name);
                end
            end
        end
        if (end_req && !end_done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
            end
            end_done = 1'b1;
        end
    end

    always @(negedge mclk) begin
        if (rtc_written) begin
            n_pulses++;
            if (prev_wr) n_wide++;
        end
        prev_wr = rtc_written;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "simulation timeout");
    end

    // One SCL period of 200; SDA only changes 50 into the low phase.
    task automatic clock_bit(input logic b, input bit collide, output logic s);
        #50 m_low = ~b;
        #50 scl_m = 1'b1;
        if (collide) begin
            rtc_load = 1'b1;
            #28 rtc_load = 1'b0;
            #22;
        end else begin
            #50;
        end
        s = sda_bus;
        #50 scl_m = 1'b0;
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            #50 m_low = 1'b0;
            #50 scl_m = 1'b1;
        end
        #100 m_low = 1'b1;
        #100 scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #50 m_low = 1'b1;
        #50 scl_m = 1'b1;
        #100 m_low = 1'b0;
        #100;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit collide, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], collide && (i == 0), s);
        clock_bit(1'b1, 1'b0, s);
        ack = !s;
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(!ack, 1'b0, s);
    endtask

    task automatic write_txn(input logic [7:0] ptr, input int n, input int collide_idx);
        logic a;
        bus_start();
        expect_item("addr_ack", 1);
        write_byte(8'hA2, 1'b0, a);
        observe("addr_ack", a);
        expect_item("ptr_ack", 1);
        write_byte(ptr, 1'b0, a);
        observe("ptr_ack", a);
        mdl_ptr = ptr[3:0];
        for (int k = 0; k < n; k++) begin
            expect_item("data_ack", 1);
            write_byte(tx_buf[k], k == collide_idx, a);
            observe("data_ack", a);
            mdl_regs[mdl_ptr] = tx_buf[k];
            if (k == collide_idx) mdl_load(rtc_in);
            mdl_ptr = mdl_ptr + 4'd1;
        end
        bus_stop();
        if (n > 0) mdl_pulses++;
    endtask

    task automatic read_txn(input int n, input bit set_ptr, input logic [7:0] ptr);
        logic       a;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            expect_item("addr_ack", 1);
            write_byte(8'hA2, 1'b0, a);
            observe("addr_ack", a);
            expect_item("ptr_ack", 1);
            write_byte(ptr, 1'b0, a);
            observe("ptr_ack", a);
            mdl_ptr = ptr[3:0];
            bus_start();
        end
        expect_item("rd_addr_ack", 1);
        write_byte(8'hA3, 1'b0, a);
        observe("rd_addr_ack", a);
        for (int k = 0; k < n; k++) begin
            expect_item("rd_data", {56'h0, mdl_regs[mdl_ptr]});
            read_byte(k < n - 1, d);
            observe("rd_data", {56'h0, d});
            if (k < n - 1) mdl_ptr = mdl_ptr + 4'd1;
        end
        #40;
        expect_item("sda_free_after_nack", 1);
        observe("sda_free_after_nack", sda_bus);
        bus_stop();
    endtask

    task automatic bad_addr_txn(input logic [7:0] a8);
        logic a;
        bus_start();
        expect_item("bad_addr_ack", 0);
        write_byte(a8, 1'b0, a);
        observe("bad_addr_ack", a);
        bus_stop();
    endtask

    task automatic check_state();
        expect_item("rtc", mdl_rtc());
        observe("rtc", rtc);
        expect_item("written_pulses", mdl_pulses);
        observe("written_pulses", n_pulses);
    endtask

    initial begin
        logic        a;
        logic [7:0]  a8;
        int unsigned kind;
        int          n;

        reset    = 1'b0;
        scl_m    = 1'b1;
        m_low    = 1'b0;
        rtc_load = 1'b0;
        rtc_in   = 56'h0;
        mdl_reset();
        mdl_pulses = 0;

        #60;
        expect_item("rst_sda", 1);
        observe("rst_sda", sda_bus);
        expect_item("rst_rtc", 0);
        observe("rst_rtc", rtc);
        expect_item("rst_written", 0);
        observe("rst_written", rtc_written);
        #40 reset = 1'b1;
        #100;

        // Full RTC write from reg2
        tx_buf = {8'h00, 8'h59, 8'h23, 8'h03, 8'h06, 8'h01, 8'h10};
        write_txn(8'h02, 7, -1);
        expect_item("rtc_full_write", 56'h00592303060110);
        observe("rtc_full_write", rtc);
        check_state();

        // Pointer set, repeated START, sequential read
        read_txn(7, 1'b1, 8'h02);
        check_state();

        // Foreign address
        bad_addr_txn(8'hA4);
        check_state();

        // Pointer wrap 0xF -> 0x0; following read continues at reg1
        tx_buf = {8'hAA, 8'hBB};
        write_txn(8'h0F, 2, -1);
        read_txn(1, 1'b0, 8'h00);
        read_txn(2, 1'b1, 8'h0F);
        check_state();

        // Host load collides with bus write to reg2
        rtc_in = 56'h11223344556677;
        tx_buf = {8'h99};
        write_txn(8'h02, 1, 0);
        expect_item("rtc_host_wins", 56'h11223344556677);
        observe("rtc_host_wins", rtc);
        check_state();

        // Reset while the slave drives a 0 data bit
        bus_start();
        expect_item("addr_ack", 1);
        write_byte(8'hA2, 1'b0, a);
        observe("addr_ack", a);
        expect_item("ptr_ack", 1);
        write_byte(8'h02, 1'b0, a);
        observe("ptr_ack", a);
        bus_start();
        expect_item("rd_addr_ack", 1);
        write_byte(8'hA3, 1'b0, a);
        observe("rd_addr_ack", a);
        #50;
        expect_item("rd_bit_driven_low", 0);
        observe("rd_bit_driven_low", sda_bus);
        reset = 1'b0;
        #10;
        expect_item("sda_free_after_reset", 1);
        observe("sda_free_after_reset", sda_bus);
        #40 reset = 1'b1;
        mdl_reset();
        check_state();
        bus_stop();
        read_txn(1, 1'b0, 8'h00);

        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    n = $urandom_range(1, 5);
                    tx_buf.delete();
                    for (int k = 0; k < n; k++) tx_buf.push_back(8'($urandom_range(0, 255)));
                    write_txn(8'($urandom_range(0, 255)), n, -1);
                end
                1: read_txn($urandom_range(1, 4), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 255)));
                2: begin
                    do a8 = 8'($urandom_range(0, 255)); while (a8[7:1] == 7'h51);
                    bad_addr_txn(a8);
                end
                3: begin
                    rtc_in   = {24'($urandom), 32'($urandom)};
                    rtc_load = 1'b1;
                    #10 rtc_load = 1'b0;
                    mdl_load(rtc_in);
                end
                default: write_txn(8'($urandom_range(0, 255)), 0, -1);
            endcase
            #100;
            check_state();
        end

        expect_item("written_pulse_width", 0);
        observe("written_pulse_width", n_wide);
        end_req = 1'b1;
        repeat (4) @(negedge mclk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
